// File: rtl/fp_pkg.sv
// fp_pkg: rounding-mode encodings, unrounded-mantissa layout and request type
// shared by the rounding arbiter and its datapath.
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;
    localparam logic [2:0] RM_DYN = 3'b111;

    // 28-bit unrounded mantissa: [27] ignored, [26:3] significand (hidden bit at 26),
    // [2] guard, [1] round, [0] sticky.
    localparam int MANT_IN_W = 28;
    localparam int MANT_HI   = 26;
    localparam int MANT_LO   = 3;
    localparam int G_BIT     = 2;
    localparam int R_BIT     = 1;
    localparam int S_BIT     = 0;

    localparam int FP_TAG_W  = 5;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [MANT_IN_W-1:0] mant;
        logic [2:0]           rm;
        logic [FP_TAG_W-1:0]  tag;
    } fp_req_t;

    // (base + off) mod n, used for the rotating arbitration pointer.
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/fp_normalize_round.sv
// fp_normalize_round: rounds a normalised 24-bit significand with G/R/S bits
// to a packed IEEE-754 single. A round-up carry out of the significand bumps
// the exponent (mod 256) and clears the fraction.
module fp_normalize_round
    import fp_pkg::*;
(
    input  logic        sign_i,
    input  logic [7:0]  exp_i,
    input  logic [26:0] mant_i,
    input  logic [2:0]  rm_i,
    output logic [31:0] data_o
);

    logic [23:0] sig;
    logic        guard;
    logic        round_b;
    logic        sticky;
    logic        inexact;
    logic        rnd_up;
    logic [24:0] sum;
    logic [7:0]  exp_r;
    logic [22:0] frac_r;
    logic        unused_hidden;

    // Decide round-up for the mode, add it in, and absorb a carry into the exponent.
    always_comb begin
        sig     = mant_i[MANT_HI:MANT_LO];
        guard   = mant_i[G_BIT];
        round_b = mant_i[R_BIT];
        sticky  = mant_i[S_BIT];
        inexact = guard | round_b | sticky;
        rnd_up  = 1'b0;
        exp_r   = exp_i;
        frac_r  = '0;
        case (rm_i)
            RM_RNE:  rnd_up = guard & (round_b | sticky | sig[0]);
            RM_RDN:  rnd_up = inexact & sign_i;
            RM_RUP:  rnd_up = inexact & ~sign_i;
            RM_RMM:  rnd_up = guard;
            default: rnd_up = 1'b0;  // RTZ, and illegal modes already forced to RTZ
        endcase
        sum = {1'b0, sig} + 25'(rnd_up);
        if (sum[24]) begin
            exp_r  = exp_i + 8'd1;
            frac_r = '0;
        end else begin
            frac_r = sum[22:0];
        end
    end

    // Hidden bit is implied in the packed result.
    assign unused_hidden = sum[23];
    assign data_o        = {sign_i, exp_r, frac_r};

endmodule

// File: rtl/fp_round_arbiter.sv
// fp_round_arbiter: round-robin shares one rounding datapath among NREQ FP
// producers. S1 holds the accepted request, the datapath sits between S1 and
// S2, and S2 drives the tagged result to writeback with valid/ready.
module fp_round_arbiter
    import fp_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = 5,
    parameter int SRC_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_sign,
    input  logic [NREQ*8-1:0]     req_exp,
    input  logic [NREQ*28-1:0]    req_mant,
    input  logic [NREQ*3-1:0]     req_rm,
    input  logic [NREQ*TAG_W-1:0] req_tag,
    input  logic [2:0]            frm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [SRC_W-1:0]      out_src,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_illegal
);

    typedef struct packed {
        logic             sign;
        logic [7:0]       exp;
        logic [26:0]      mant;
        logic [2:0]       rm;
        logic             ill;
        logic [SRC_W-1:0] src;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [31:0]      data;
        logic [SRC_W-1:0] src;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } s2_t;

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]  grant;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand;
    logic             found;
    logic             s1_free, s1_adv, accept;
    logic [2:0]       sel_rm, rm_eff;
    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    s1_t              s1_in, s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic [2:0]       dp_rm;
    logic [31:0]      dp_data;
    logic [NREQ-1:0]  unused_mant_msb;

    // Bit 27 of each mantissa carries no information.
    for (genvar i = 0; i < NREQ; i++) begin : g_mant_msb
        assign unused_mant_msb[i] = req_mant[28*i+27];
    end

    // Rotating-priority pick: first valid requester at or after rr_ptr_q.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = SRC_W'(wrap_add(int'(rr_ptr_q), k, NREQ));
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // S1 takes a new request when empty or draining this cycle; handshakes stay
    // silent while reset is asserted.
    assign s1_adv    = s1_valid_q & (~s2_valid_q | out_ready);
    assign s1_free   = ~s1_valid_q | s1_adv;
    assign req_ready = grant & {NREQ{s1_free & rst_n}};
    assign accept    = |req_ready;

    // Gather the granted request; frm is resolved here so only the accept-cycle value counts.
    always_comb begin
        sel_rm     = req_rm[3*grant_idx +: 3];
        rm_eff     = (sel_rm == RM_DYN) ? frm : sel_rm;
        s1_in      = '0;
        s1_in.sign = req_sign[grant_idx];
        s1_in.exp  = req_exp[8*grant_idx +: 8];
        s1_in.mant = req_mant[28*grant_idx +: 27];
        s1_in.rm   = rm_eff;
        s1_in.ill  = (rm_eff == 3'b101) || (rm_eff == 3'b110) || (rm_eff == 3'b111);
        s1_in.src  = grant_idx;
        s1_in.tag  = req_tag[TAG_W*grant_idx +: TAG_W];
    end

    // Illegal modes still produce a result, truncated.
    assign dp_rm = s1_q.ill ? RM_RTZ : s1_q.rm;

    fp_normalize_round u_round (
        .sign_i (s1_q.sign),
        .exp_i  (s1_q.exp),
        .mant_i (s1_q.mant),
        .rm_i   (dp_rm),
        .data_o (dp_data)
    );

    // Next state for the pointer and both pipeline stages.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s2_valid_d = s2_valid_q;
        s2_d       = s2_q;
        if (accept) begin
            rr_ptr_d   = SRC_W'(wrap_add(int'(grant_idx), 1, NREQ));
            s1_d       = s1_in;
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_d.data  = dp_data;
            s2_d.src   = s1_q.src;
            s2_d.tag   = s1_q.tag;
            s2_d.ill   = s1_q.ill;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_q       <= s2_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_data    = s2_q.data;
    assign out_src     = s2_q.src;
    assign out_tag     = s2_q.tag;
    assign out_illegal = s2_q.ill;

endmodule

// File: tb/tb_fp_round_arbiter.sv
// Directed bench for fp_round_arbiter: hand-computed IEEE results, arbitration
// order, backpressure and reset behaviour.
module tb_fp_round_arbiter;
    import fp_pkg::*;

    localparam int NREQ  = 4;
    localparam int TAG_W = 5;
    localparam int SRC_W = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_ready, req_sign;
    logic [NREQ*8-1:0]     req_exp;
    logic [NREQ*28-1:0]    req_mant;
    logic [NREQ*3-1:0]     req_rm;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [2:0]            frm;
    logic                  out_valid, out_ready;
    logic [31:0]           out_data;
    logic [SRC_W-1:0]      out_src;
    logic [TAG_W-1:0]      out_tag;
    logic                  out_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_round_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .SRC_W(SRC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
        .req_exp(req_exp), .req_mant(req_mant), .req_rm(req_rm), .req_tag(req_tag),
        .frm(frm), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .out_tag(out_tag), .out_illegal(out_illegal)
    );

    task automatic set_req(input int i, input logic s, input logic [7:0] e, input logic [27:0] m,
                           input logic [2:0] rm, input logic [TAG_W-1:0] t);
        req_sign[i]              = s;
        req_exp[8*i +: 8]        = e;
        req_mant[28*i +: 28]     = m;
        req_rm[3*i +: 3]         = rm;
        req_tag[TAG_W*i +: TAG_W] = t;
    endtask

    // Issue one request alone, then return what comes out and how many cycles it took.
    task automatic run_one(input int i, input logic s, input logic [7:0] e, input logic [27:0] m,
                           input logic [2:0] rm, input logic [TAG_W-1:0] t, input logic [2:0] f,
                           output logic [31:0] d, output logic [SRC_W-1:0] src,
                           output logic [TAG_W-1:0] tg, output logic ill, output int lat, output bit got);
        got = 1'b0; lat = 0; d = '0; src = '0; tg = '0; ill = 1'b0;
        set_req(i, s, e, m, rm, t);
        frm = f; out_ready = 1'b1; req_valid = '0; req_valid[i] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[i]) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = '0; frm = 3'b000;
        if (got) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    lat = c; d = out_data; src = out_src; tg = out_tag; ill = out_illegal;
                    break;
                end
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req_valid = '1; out_ready = 1'b1; frm = 3'b000;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h7F, 28'h4000000, RM_RNE, 5'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_src !== 2'd0 || out_tag !== 5'd0 || out_illegal !== 1'b0) begin
            failures++; $display("FAIL reset_sideband src=%0d tag=%0d ill=%b exp=0/0/0", out_src, out_tag, out_illegal); end
        req_valid = '0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_rne_tie();
        logic [31:0] d; logic [SRC_W-1:0] s; logic [TAG_W-1:0] t; logic il; int lat; bit got;
        run_one(0, 1'b0, 8'h7F, 28'h4000004, RM_RNE, 5'd5, 3'b000, d, s, t, il, lat, got);
        checks++; if (!got) begin failures++; $display("FAIL rne_accept got=0 exp=1"); end
        checks++; if (d !== 32'h3F800000) begin failures++; $display("FAIL rne_data got=%h exp=3f800000", d); end
        checks++; if (s !== 2'd0 || t !== 5'd5) begin failures++; $display("FAIL rne_src_tag got=%0d/%0d exp=0/5", s, t); end
        checks++; if (lat != 2) begin failures++; $display("FAIL rne_latency got=%0d exp=2", lat); end
        checks++; if (il !== 1'b0) begin failures++; $display("FAIL rne_illegal got=%b exp=0", il); end
    endtask

    task automatic test_round_carry();
        logic [31:0] d; logic [SRC_W-1:0] s; logic [TAG_W-1:0] t; logic il; int lat; bit got;
        run_one(1, 1'b0, 8'h7F, 28'h7FFFFFE, RM_RNE, 5'd7, 3'b000, d, s, t, il, lat, got);
        checks++; if (d !== 32'h40000000) begin failures++; $display("FAIL carry_rne_data got=%h exp=40000000", d); end
        checks++; if (s !== 2'd1 || t !== 5'd7) begin failures++; $display("FAIL carry_src_tag got=%0d/%0d exp=1/7", s, t); end
        run_one(2, 1'b0, 8'h7F, 28'h7FFFFFE, RM_RTZ, 5'd8, 3'b000, d, s, t, il, lat, got);
        checks++; if (d !== 32'h3FFFFFFF) begin failures++; $display("FAIL carry_rtz_data got=%h exp=3fffffff", d); end
        checks++; if (s !== 2'd2) begin failures++; $display("FAIL carry_rtz_src got=%0d exp=2", s); end
    endtask

    task automatic test_direction();
        logic [31:0] d; logic [SRC_W-1:0] s; logic [TAG_W-1:0] t; logic il; int lat; bit got;
        run_one(3, 1'b1, 8'h7F, 28'h4000001, RM_RUP, 5'd9, 3'b000, d, s, t, il, lat, got);
        checks++; if (d !== 32'hBF800000) begin failures++; $display("FAIL rup_neg_data got=%h exp=bf800000", d); end
        run_one(0, 1'b1, 8'h7F, 28'h4000001, RM_RDN, 5'd10, 3'b000, d, s, t, il, lat, got);
        checks++; if (d !== 32'hBF800001) begin failures++; $display("FAIL rdn_neg_data got=%h exp=bf800001", d); end
        run_one(0, 1'b0, 8'h7F, 28'h4000004, RM_RMM, 5'd11, 3'b000, d, s, t, il, lat, got);
        checks++; if (d !== 32'h3F800001) begin failures++; $display("FAIL rmm_tie_data got=%h exp=3f800001", d); end
    endtask

    task automatic test_dyn_illegal();
        logic [31:0] d; logic [SRC_W-1:0] s; logic [TAG_W-1:0] t; logic il; int lat; bit got;
        // frm is changed to RNE right after accept; the result must still be RUP.
        run_one(1, 1'b0, 8'h7F, 28'h4000001, RM_DYN, 5'd12, RM_RUP, d, s, t, il, lat, got);
        checks++; if (d !== 32'h3F800001) begin failures++; $display("FAIL dyn_rup_data got=%h exp=3f800001", d); end
        checks++; if (il !== 1'b0) begin failures++; $display("FAIL dyn_rup_illegal got=%b exp=0", il); end
        run_one(2, 1'b0, 8'h7F, 28'h7FFFFFE, 3'b101, 5'd13, 3'b000, d, s, t, il, lat, got);
        checks++; if (d !== 32'h3FFFFFFF || il !== 1'b1) begin
            failures++; $display("FAIL rm101_illegal got=%h/%b exp=3fffffff/1", d, il); end
        run_one(3, 1'b0, 8'h7F, 28'h7FFFFFE, RM_DYN, 5'd14, 3'b110, d, s, t, il, lat, got);
        checks++; if (d !== 32'h3FFFFFFF || il !== 1'b1) begin
            failures++; $display("FAIL dyn_frm110_illegal got=%h/%b exp=3fffffff/1", d, il); end
    endtask

    // All four requesters held valid: grants rotate and results stream one per cycle.
    task automatic test_fairness_back_to_back();
        int gq[$]; int sq[$]; int tq[$]; int first_c; int last_c;
        first_c = -1; last_c = -1;
        rst_n = 1'b0; req_valid = '0; out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h7F, 28'h4000000 | (28'(i) << 3), RM_RNE, 5'(i));
        req_valid = '1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c < 8) for (int k = 0; k < NREQ; k++) if (req_ready[k]) gq.push_back(k);
            if (out_valid) begin
                sq.push_back(int'(out_src)); tq.push_back(int'(out_tag));
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            @(posedge clk); #1;
            if (c == 7) req_valid = '0;
        end
        checks++; if (gq.size() != 8) begin failures++; $display("FAIL fair_grant_count got=%0d exp=8", gq.size()); end
        checks++; if (sq.size() != 8) begin failures++; $display("FAIL fair_result_count got=%0d exp=8", sq.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (gq[i] != i % 4) begin failures++; $display("FAIL fair_grant[%0d] got=%0d exp=%0d", i, gq[i], i % 4); end
            checks++; if (sq[i] != i % 4 || tq[i] != i % 4) begin
                failures++; $display("FAIL fair_out_src[%0d] got=%0d tag=%0d exp=%0d", i, sq[i], tq[i], i % 4); end
        end
        checks++; if (first_c != 2 || last_c != 9) begin
            failures++; $display("FAIL fair_full_rate first=%0d last=%0d exp=2/9", first_c, last_c); end
    endtask

    task automatic test_backpressure();
        int acc[$]; int rs[$]; logic [31:0] rd[$]; logic [31:0] d0; logic [TAG_W-1:0] t0; bit seen; bit stable;
        seen = 1'b0; stable = 1'b1; d0 = '0; t0 = '0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 8'h10 + 8'(i), 28'h4000000, RM_RNE, 5'(10 + i));
        out_ready = 1'b0; req_valid = 4'b0111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) acc.push_back(k);
            if (out_valid) begin
                if (!seen) begin seen = 1'b1; d0 = out_data; t0 = out_tag; end
                else if (out_data !== d0 || out_tag !== t0) stable = 1'b0;
            end
            @(posedge clk); #1;
            foreach (acc[j]) req_valid[acc[j]] = 1'b0;
        end
        checks++; if (acc.size() != 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", acc.size()); end
        checks++; if (d0 !== 32'h08000000 || t0 !== 5'd10) begin failures++; $display("FAIL bp_head got=%h/%0d exp=08000000/10", d0, t0); end
        checks++; if (!stable) begin failures++; $display("FAIL bp_stable got=changed exp=stable"); end
        @(negedge clk);
        checks++; if (req_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 32'h08000000) begin
            failures++; $display("FAIL bp_stall ready=%b valid=%b data=%h exp=0000/1/08000000", req_ready, out_valid, out_data); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < NREQ; k++) if (req_ready[k]) acc.push_back(k);
            if (out_valid) begin rs.push_back(int'(out_src)); rd.push_back(out_data); end
            @(posedge clk); #1;
            foreach (acc[j]) req_valid[acc[j]] = 1'b0;
        end
        req_valid = '0;
        checks++; if (acc.size() != 3 || acc[2] != 2) begin failures++; $display("FAIL bp_accept_order n=%0d last=%0d exp=3/2", acc.size(), acc[2]); end
        checks++; if (rs.size() != 3) begin failures++; $display("FAIL bp_result_count got=%0d exp=3", rs.size()); end
        checks++; if (rs[0] != 0 || rs[1] != 1 || rs[2] != 2) begin
            failures++; $display("FAIL bp_result_src got=%0d,%0d,%0d exp=0,1,2", rs[0], rs[1], rs[2]); end
        checks++; if (rd[0] !== 32'h08000000 || rd[1] !== 32'h08800000 || rd[2] !== 32'h09000000) begin
            failures++; $display("FAIL bp_result_data got=%h,%h,%h exp=08000000,08800000,09000000", rd[0], rd[1], rd[2]); end
    endtask

    task automatic test_reset_midflight();
        bit leak;
        leak = 1'b0;
        for (int i = 1; i < NREQ; i++) set_req(i, 1'b0, 8'h20 + 8'(i), 28'h4000000, RM_RNE, 5'(20 + i));
        out_ready = 1'b0; req_valid = 4'b0110;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || req_ready !== 4'b0000) begin
            failures++; $display("FAIL mid_fill valid=%b ready=%b exp=1/0000", out_valid, req_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0) begin
            failures++; $display("FAIL mid_reset valid=%b data=%h tag=%0d exp=0/0/0", out_valid, out_data, out_tag); end
        req_valid = '0; out_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) leak = 1'b1;
        end
        checks++; if (leak) begin failures++; $display("FAIL mid_no_leak got=output exp=none"); end
        @(posedge clk); #1;
        req_valid = 4'b1010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_rr_ptr ready=%b exp=0010", req_ready); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_sign = '0; req_exp = '0; req_mant = '0;
        req_rm = '0; req_tag = '0; frm = 3'b000; out_ready = 1'b1;
        test_reset();
        test_rne_tie();
        test_round_carry();
        test_direction();
        test_dyn_illegal();
        test_fairness_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
